// File: rtl/cpu_pkg.sv
// Shared encodings for the multicycle control unit: FSM states, opcodes,
// ALUOp/PCSrc codes and the DECODE dispatch helper.
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_BRANCH = 3'd6,
    ST_JUMP   = 3'd7
  } state_t;

  localparam logic [3:0] OP_R    = 4'h0;
  localparam logic [3:0] OP_LW   = 4'h4;
  localparam logic [3:0] OP_SW   = 4'h5;
  localparam logic [3:0] OP_BEQ  = 4'h6;
  localparam logic [3:0] OP_ADDI = 4'h7;
  localparam logic [3:0] OP_J    = 4'h8;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_INC = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_JMP = 2'b10;

  // Returns ST_FETCH for any illegal opcode, which the caller flags as Illegal.
  function automatic state_t decode_target(input logic [3:0] op, input logic hi_nz);
    state_t t;
    if (hi_nz) begin
      t = ST_FETCH;
    end else begin
      case (op)
        OP_R, OP_LW, OP_SW, OP_ADDI: t = ST_EXEC;
        OP_BEQ:                      t = ST_BRANCH;
        OP_J:                        t = ST_JUMP;
        default:                     t = ST_FETCH;
      endcase
    end
    return t;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Saturating count of memory-wait cycles; expired_o flags the cycle in which
// the count has reached TIMEOUT.
module mem_wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clear_i,
  input  logic inc_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear wins, otherwise count up and hold at LIMIT.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == LIMIT);

endmodule

// File: rtl/multicycle_cu.sv
// Multicycle CPU control unit: FETCH/DECODE/EXEC/MEM/WB/BRANCH/JUMP FSM with a
// bounded memory wait that aborts back to FETCH with a MemErr pulse.
module multicycle_cu
  import cpu_pkg::*;
#(
  parameter int OPW     = 4,
  parameter int FW      = 4,
  parameter int TIMEOUT = 15
) (
  input  logic           Clock,
  input  logic           ResetN,
  input  logic [OPW-1:0] opcode,
  input  logic [FW-1:0]  funct,
  input  logic           Zero,
  input  logic           MemReady,
  output logic           RegDst,
  output logic           Branch,
  output logic           MemRead,
  output logic           MemWrite,
  output logic           RegWrite,
  output logic           MemToReg,
  output logic           ALUSrc,
  output logic [1:0]     ALUOp,
  output logic           PCWrite,
  output logic           IRWrite,
  output logic           IorD,
  output logic [1:0]     PCSrc,
  output logic [2:0]     State,
  output logic           InstrDone,
  output logic           Illegal,
  output logic           MemErr
);

  state_t          state_q, state_d;
  logic [3:0]      op_q, op_d;
  logic [FW-1:0]   funct_q, funct_d;
  logic            op_hi_nz_s;
  logic            expired_s;
  logic            timer_inc_s;
  logic            timer_clear_s;

  assign op_hi_nz_s = |(opcode >> 3'd4);
  assign State      = state_q;

  mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk_i     (Clock),
    .rst_n_i   (ResetN),
    .clear_i   (timer_clear_s),
    .inc_i     (timer_inc_s),
    .expired_o (expired_s)
  );

  // Next state and Mealy control outputs; later phases use only latched op_q.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    funct_d   = funct_q;
    RegDst    = 1'b0;
    Branch    = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    RegWrite  = 1'b0;
    MemToReg  = 1'b0;
    ALUSrc    = 1'b0;
    ALUOp     = ALUOP_ADD;
    PCWrite   = 1'b0;
    IRWrite   = 1'b0;
    IorD      = 1'b0;
    PCSrc     = PCSRC_INC;
    InstrDone = 1'b0;
    Illegal   = 1'b0;
    MemErr    = 1'b0;
    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        MemRead = 1'b1;
        if (MemReady) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          PCSrc   = PCSRC_INC;
          state_d = ST_DECODE;
        end else if (expired_s) begin
          MemErr  = 1'b1;
          state_d = ST_FETCH;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_DECODE: begin
        op_d    = opcode[3:0];
        funct_d = funct;
        state_d = decode_target(opcode[3:0], op_hi_nz_s);
        if (decode_target(opcode[3:0], op_hi_nz_s) == ST_FETCH) begin
          Illegal = 1'b1;
        end else begin
          Illegal = 1'b0;
        end
      end
      ST_EXEC: begin
        case (op_q)
          OP_R: begin
            ALUOp   = ALUOP_FUNCT;
            state_d = ST_WB;
          end
          OP_ADDI: begin
            ALUSrc  = 1'b1;
            state_d = ST_WB;
          end
          OP_LW, OP_SW: begin
            ALUSrc  = 1'b1;
            state_d = ST_MEM;
          end
          default: state_d = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        IorD = 1'b1;
        if (op_q == OP_LW) begin
          MemRead = 1'b1;
        end else begin
          MemWrite = 1'b1;
        end
        if (MemReady) begin
          if (op_q == OP_LW) begin
            state_d = ST_WB;
          end else begin
            InstrDone = 1'b1;
            state_d   = ST_FETCH;
          end
        end else if (expired_s) begin
          MemErr  = 1'b1;
          state_d = ST_FETCH;
        end else begin
          state_d = ST_MEM;
        end
      end
      ST_WB: begin
        RegWrite  = 1'b1;
        InstrDone = 1'b1;
        if (op_q == OP_R) begin
          RegDst = 1'b1;
        end else begin
          RegDst = 1'b0;
        end
        if (op_q == OP_LW) begin
          MemToReg = 1'b1;
        end else begin
          MemToReg = 1'b0;
        end
        state_d = ST_FETCH;
      end
      ST_BRANCH: begin
        Branch    = 1'b1;
        ALUOp     = ALUOP_SUB;
        PCSrc     = PCSRC_BR;
        PCWrite   = Zero;
        InstrDone = 1'b1;
        state_d   = ST_FETCH;
      end
      ST_JUMP: begin
        PCWrite   = 1'b1;
        PCSrc     = PCSRC_JMP;
        InstrDone = 1'b1;
        state_d   = ST_FETCH;
      end
      default: state_d = ST_IDLE;
    endcase
    // A fresh request (new state or retry after timeout) restarts the count.
    timer_inc_s   = ((state_q == ST_FETCH) || (state_q == ST_MEM)) && !MemReady;
    timer_clear_s = (state_d != state_q) || MemErr;
  end

  // State and latched instruction fields.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state_q <= ST_IDLE;
      op_q    <= 4'h0;
      funct_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      funct_q <= funct_d;
    end
  end

endmodule
